// File: rtl/serial_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : serial_program_loader
// Description : Loads a framed program from the UART byte stream into program
//               RAM and restarts the CPU once the checksum verifies.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_program_loader #(
    parameter int unsigned ADDR_WIDTH     = 11,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 16000000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    output logic                  cpu_hold,
    output logic                  cpu_restart,
    output logic                  load_done,
    output logic                  load_error,
    output logic                  busy
);

    localparam int unsigned        c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]        c_MAX_LEN  = 17'(2 ** ADDR_WIDTH);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LEN0  = 4'd1,
        S_LEN1  = 4'd2,
        S_DATA  = 4'd3,
        S_WRITE = 4'd4,
        S_CSUM  = 4'd5,
        S_DONE  = 4'd6,
        S_ERROR = 4'd7
    } state_t;

    state_t                r_state;
    logic [15:0]           r_len;
    logic [7:0]            r_csum;
    logic [ADDR_WIDTH:0]   r_word_cnt;
    logic [1:0]            r_idx;
    logic [23:0]           r_word;
    logic [c_TMO_W-1:0]    r_tmo;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [31:0]           r_ram_wdata;
    logic                  r_cpu_hold;
    logic                  r_cpu_restart;
    logic                  r_load_done;
    logic                  r_load_error;

    logic                  w_accept;
    logic                  w_count_state;
    logic                  w_timeout;
    logic [15:0]           w_len_full;
    logic [7:0]            w_csum_next;
    logic [ADDR_WIDTH:0]   w_cnt_next;

    assign rx_ready      = (r_state == S_IDLE) || (r_state == S_LEN0) || (r_state == S_LEN1) ||
                           (r_state == S_DATA) || (r_state == S_CSUM);
    assign busy          = (r_state != S_IDLE);
    assign w_accept      = rx_valid && rx_ready;
    assign w_count_state = rx_ready && (r_state != S_IDLE);
    assign w_timeout     = w_count_state && !w_accept && (r_tmo == c_TMO_LAST);
    assign w_len_full    = {rx_data, r_len[7:0]};
    assign w_csum_next   = r_csum + rx_data;
    assign w_cnt_next    = r_word_cnt + 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_csum        <= '0;
            r_word_cnt    <= '0;
            r_idx         <= '0;
            r_word        <= '0;
            r_tmo         <= '0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_wdata   <= '0;
            r_cpu_hold    <= 1'b0;
            r_cpu_restart <= 1'b0;
            r_load_done   <= 1'b0;
            r_load_error  <= 1'b0;
        end else begin
            r_ram_we      <= 1'b0;
            r_cpu_restart <= 1'b0;
            r_load_done   <= 1'b0;

            if (w_accept || (r_state == S_IDLE)) begin
                r_tmo <= '0;
            end else if (w_count_state) begin
                r_tmo <= r_tmo + 1'b1;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (w_accept && (rx_data == SYNC_BYTE)) begin
                        r_load_error <= 1'b0;
                        r_cpu_hold   <= 1'b1;
                        r_csum       <= '0;
                        r_word_cnt   <= '0;
                        r_state      <= S_LEN0;
                    end
                end
                S_LEN0: begin
                    if (w_accept) begin
                        r_len[7:0] <= rx_data;
                        r_csum     <= w_csum_next;
                        r_state    <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (w_accept) begin
                        r_len[15:8] <= rx_data;
                        r_csum      <= w_csum_next;
                        if ({1'b0, w_len_full} > c_MAX_LEN) begin
                            r_load_error <= 1'b1;
                            r_state      <= S_ERROR;
                        end else if (w_len_full == 16'd0) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_idx   <= '0;
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_csum <= w_csum_next;
                        // Little-endian: bytes shift in from the top so byte 0 lands in [7:0].
                        if (r_idx == 2'd3) begin
                            r_ram_we    <= 1'b1;
                            r_ram_addr  <= r_word_cnt[ADDR_WIDTH-1:0];
                            r_ram_wdata <= {rx_data, r_word};
                            r_state     <= S_WRITE;
                        end else begin
                            r_word <= {rx_data, r_word[23:8]};
                            r_idx  <= r_idx + 2'd1;
                        end
                    end
                end
                S_WRITE: begin
                    r_word_cnt <= w_cnt_next;
                    r_idx      <= '0;
                    r_state    <= (17'(w_cnt_next) == 17'(r_len)) ? S_CSUM : S_DATA;
                end
                S_CSUM: begin
                    if (w_accept) begin
                        if (rx_data == r_csum) begin
                            r_load_done   <= 1'b1;
                            r_cpu_restart <= 1'b1;
                            r_cpu_hold    <= 1'b0;
                            r_state       <= S_DONE;
                        end else begin
                            r_load_error <= 1'b1;
                            r_state      <= S_ERROR;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ERROR: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            // Only fires when no byte was taken, so it never races a state advance.
            if (w_timeout) begin
                r_load_error <= 1'b1;
                r_state      <= S_ERROR;
            end
        end
    end

    assign ram_we      = r_ram_we;
    assign ram_addr    = r_ram_addr;
    assign ram_wdata   = r_ram_wdata;
    assign cpu_hold    = r_cpu_hold;
    assign cpu_restart = r_cpu_restart;
    assign load_done   = r_load_done;
    assign load_error  = r_load_error;

endmodule
`default_nettype wire

// File: tb/tb_serial_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_program_loader
// Description : Directed self-checking bench for serial_program_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_program_loader;

    localparam int unsigned AW = 11;
    localparam int unsigned T  = 40;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          cpu_hold;
    logic          cpu_restart;
    logic          load_done;
    logic          load_error;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:2047];
    int n_we = 0, n_done = 0, n_restart = 0, n_rdy_we = 0;
    int b_we, b_done, b_restart;
    logic [7:0] cs;

    serial_program_loader #(
        .ADDR_WIDTH    (AW),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .cpu_hold   (cpu_hold),
        .cpu_restart(cpu_restart),
        .load_done  (load_done),
        .load_error (load_error),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // RAM write and pulse monitor
    always @(negedge CLK) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            n_we          <= n_we + 1;
            if (rx_ready) n_rdy_we <= n_rdy_we + 1;
        end
        if (load_done)   n_done    <= n_done + 1;
        if (cpu_restart) n_restart <= n_restart + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a byte and returns 1 ns after the edge on which it was taken.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge CLK);
        while (!rx_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) check("byte_accept_timeout", 32'(n), 32'd0);
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_two_word_frame(input logic [7:0] csum);
        logic [7:0] f [0:11];
        f = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
              8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
        f[11] = csum;
        for (int i = 0; i < 12; i++) begin
            send_byte(f[i]);
            if (i == 0) begin
                check("hold_after_sync", 32'(cpu_hold), 32'd1);
                check("error_clear_on_sync", 32'(load_error), 32'd0);
            end
        end
    endtask

    task automatic snap();
        b_we = n_we; b_done = n_done; b_restart = n_restart;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", {27'd0, ram_we, cpu_hold, cpu_restart, load_done, load_error}, 32'd0);
        check("rst_ram_bus", {ram_wdata[30:0], 1'b0} | 32'(ram_addr), 32'd0);
        @(posedge CLK); #1;

        // Valid two-word load; checksum 0x4E
        snap();
        send_two_word_frame(8'h4E);
        check("done_pulse", {29'd0, load_done, cpu_restart, cpu_hold}, 32'b110);
        check("done_rx_ready_low", 32'(rx_ready), 32'd0);
        @(posedge CLK); #1;
        check("done_one_cycle", {30'd0, load_done, busy}, 32'd0);
        check("ok_word0", mem[0], 32'h12345678);
        check("ok_word1", mem[1], 32'hDEADBEEF);
        check("ok_we_count", 32'(n_we - b_we), 32'd2);
        check("ok_done_count", 32'(n_done - b_done), 32'd1);
        check("ok_restart_count", 32'(n_restart - b_restart), 32'd1);
        check("ok_no_error", 32'(load_error), 32'd0);

        // Bad checksum, then recovery
        snap();
        send_two_word_frame(8'h4F);
        check("badcs_error", 32'(load_error), 32'd1);
        @(posedge CLK); #1;
        check("badcs_we_count", 32'(n_we - b_we), 32'd2);
        check("badcs_no_done", 32'(n_done - b_done), 32'd0);
        check("badcs_hold", {30'd0, cpu_hold, busy}, 32'b10);
        snap();
        send_two_word_frame(8'h4E);
        @(posedge CLK); #1;
        check("recover_done", 32'(n_done - b_done), 32'd1);
        check("recover_hold", {30'd0, cpu_hold, load_error}, 32'd0);

        // Oversize length 2049
        snap();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h08);
        check("oversize_error", {30'd0, load_error, rx_ready}, 32'b10);
        @(posedge CLK); #1;
        check("oversize_idle", {30'd0, busy, cpu_hold}, 32'b01);
        check("oversize_no_we", 32'(n_we - b_we), 32'd0);

        // Inter-byte timeout
        snap();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h78);
        send_byte(8'h56);
        repeat (T - 1) @(posedge CLK);
        #1;
        check("tmo_not_yet", {30'd0, load_error, busy}, 32'b01);
        @(posedge CLK); #1;
        check("tmo_error", 32'(load_error), 32'd1);
        @(posedge CLK); #1;
        check("tmo_idle", 32'(busy), 32'd0);
        send_byte(8'h34);
        check("tmo_discard", {30'd0, busy, load_error}, 32'b01);
        check("tmo_no_we", 32'(n_we - b_we), 32'd0);

        // Junk then zero-length frame with rx_valid held high throughout
        snap();
        send_byte(8'h00);
        send_byte(8'hFF);
        check("junk_ignored", 32'(busy), 32'd0);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        check("zero_len_done", {30'd0, load_done, cpu_hold}, 32'b10);
        check("zero_len_no_we", 32'(n_we - b_we), 32'd0);

        // len = 1: byte held across WRITE is taken the cycle after
        @(posedge CLK); #1;
        snap();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        rx_valid = 1'b1;
        rx_data  = 8'hAB;
        check("write_strobe", {30'd0, ram_we, rx_ready}, 32'b10);
        check("write_data", ram_wdata, 32'h44332211);
        check("write_addr", 32'(ram_addr), 32'd0);
        @(posedge CLK); #1;
        check("held_not_taken", {29'd0, ram_we, rx_ready, load_done}, 32'b010);
        @(posedge CLK); #1;
        rx_valid = 1'b0;
        check("held_taken_done", 32'(load_done), 32'd1);
        check("len1_we_count", 32'(n_we - b_we), 32'd1);

        // Maximum length 2048 words; word k = k
        @(posedge CLK); #1;
        snap();
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h08);
        cs = 8'h08;
        for (int k = 0; k < 2048; k++) begin
            send_byte(8'(k));
            send_byte(8'(k >> 8));
            send_byte(8'h00);
            send_byte(8'h00);
            cs = cs + 8'(k) + 8'(k >> 8);
        end
        send_byte(cs);
        check("max_done", 32'(load_done), 32'd1);
        check("max_we_count", 32'(n_we - b_we), 32'd2048);
        check("max_top_word", mem[2047], 32'h000007FF);
        check("max_first_word", mem[0], 32'h00000000);
        check("max_last_addr", 32'(ram_addr), 32'd2047);
        @(posedge CLK); #1;

        // Asynchronous reset mid-DATA
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2 RST = 1'b1;
        #1;
        check("arst_flags", {26'd0, busy, cpu_hold, ram_we, load_done, load_error, cpu_restart}, 32'd0);
        check("arst_rx_ready", 32'(rx_ready), 32'd1);
        check("arst_ram_bus", ram_wdata | 32'(ram_addr), 32'd0);
        @(posedge CLK); #1 RST = 1'b0;
        snap();
        send_two_word_frame(8'h4E);
        @(posedge CLK); #1;
        check("post_rst_word0", mem[0], 32'h12345678);
        check("post_rst_word1", mem[1], 32'hDEADBEEF);
        check("post_rst_done", 32'(n_done - b_done), 32'd1);

        check("ready_low_during_we", 32'(n_rdy_we), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
